mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and load-data formatter for the MIPS32 pipeline. Captures MEM-stage results on the rising clock edge and extracts/sign-extends load bytes from the word-aligned data-memory read. Drives the register-file write port (`waddr`/`wdata`/`we`), which commits on the falling edge of the same WB cycle. The same outputs act as the WB forwarding source for the ID/EX bypass network.

## Interface

- `RESET_PC`, default 32'hBFC00000: value of `wb_pc` after reset or flush.

- `clk` in 1: single pipeline clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold all WB state (hazard unit).
- `flush` in 1: load a bubble (exception/ERET).
- `mem_valid` in 1: MEM slot holds a real instruction.
- `mem_pc` in 32: PC of the MEM instruction.
- `mem_we` in 1: instruction writes a GPR.
- `mem_waddr` in 5: destination GPR.
- `mem_alu_result` in 32: ALU result; load byte address for loads.
- `mem_load_op` in 3: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `mem_rdata` in 32: word-aligned data-memory read data, valid in MEM cycle.
- `mem_rt_data` in 32: old rt value; merge source for LWL/LWR.
- `waddr` out 5, `wdata` out 32, `we` out 1: register-file write port.
- `wb_valid` out 1: WB slot valid.
- `wb_pc` out 32: PC of the WB instruction.
- `load_err` out 1: misaligned or disabled load dropped this cycle.
- `instret` out 32: count of retired valid instructions.

## Operation

- Formatting is combinational on MEM inputs, registered at the edge. Let a = `mem_alu_result[1:0]`; memory is little-endian, byte a = `mem_rdata[8a+7:8a]`.
- Load ops 0–7 (`rt` = `mem_rt_data`):
  - 0: wdata = `mem_alu_result`.
  - 1/2 (LB/LBU): byte a, sign-/zero-extended.
  - 3/4 (LH/LHU): halfword a[1], sign-/zero-extended.
  - 5 (LW): `mem_rdata`.
  - 6 (LWL), by a = 0/1/2/3: {rdata[7:0],rt[23:0]}, {rdata[15:0],rt[15:0]}, {rdata[23:0],rt[7:0]}, rdata.
  - 7 (LWR), by a = 0/1/2/3: rdata, {rt[31:24],rdata[31:8]}, {rt[31:16],rdata[31:16]}, {rt[31:8],rdata[31:24]}.
- Misalignment: LH/LHU with a[0]=1, or LW with a≠0 -> captured `we`=0, `load_err`=1 for that WB cycle; `wb_valid` stays 1. Upstream normally traps these; this is a safety net.
- `we` = `mem_valid & mem_we & (mem_waddr≠0) & ~err`. A write to $0 is never asserted, so bypass never matches $0.
- `instret` increments by 1 on each edge where a valid instruction is captured (not stalled, not flushed, `mem_valid`=1). Wraps 32'hFFFFFFFF -> 0.
- Update priority each edge: `rst` > `flush` > `stall` > capture.

## Timing

- Latency: 1 cycle, MEM inputs -> WB outputs. The register file commits at the following negedge, so ID reads the new value in the same cycle.
- Reset: `waddr`=0, `wdata`=0, `we`=0, `wb_valid`=0, `wb_pc`=`RESET_PC`, `load_err`=0, `instret`=0.
- Flush (with or without stall): same values as reset except `instret`, which is held.
- Stall: all outputs hold. A held `we`=1 rewrites the identical value, which is harmless. `load_err` also holds.
- Reset or flush mid-stall discards the held instruction. There is no outstanding state beyond one slot.

## Configuration

- `WB_LWLR_EN` defined: load ops 6/7 perform LWL/LWR merges as above.
- Undefined: no merge logic and `mem_rt_data` is unused; ops 6/7 are handled like misaligned loads (`we`=0, `load_err`=1).

## Test plan

- LB at addr 0x...03, rdata 0x80FF1234 -> wdata 0xFFFFFF80, `we`=1. LBU at the same address -> 0x00000080.
- LH at addr ...2, rdata 0x9ABC1234 -> wdata 0xFFFF9ABC. LW at addr ...1 -> `we`=0, `load_err`=1, `wb_valid`=1.
- With `WB_LWLR_EN`: LWL a=1, rdata 0x11223344, rt 0xAABBCCDD -> 0x3344CCDD. LWR a=2 -> 0xAABB1122. Without it, both ops -> `we`=0, `load_err`=1.
- ALU op to waddr 0, value 0x5 -> `we`=0, `wb_valid`=1, `instret` increments.
- Capture waddr 7 / 0x1234, then stall 3 cycles -> outputs unchanged and `instret` +1 only. Flush during the stall -> `we`=0, `wb_valid`=0, `wb_pc`=`RESET_PC`.
- Preload `instret`=0xFFFFFFFF via 2^32 retires (or force), retire one more -> 0. Assert `rst` mid-stream -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load-data formatting.
// Extracts and extends load bytes/halfwords from the word-aligned read data
// and drives the register-file write port / WB forwarding source.
// Optional feature macro: WB_LWLR_EN enables the LWL/LWR unaligned merges;
// when undefined, ops 6/7 are dropped as load errors and mem_rt_data is unused.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_alu_result,
    input  logic [2:0]  mem_load_op,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_rt_data,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        we,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        load_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } load_op_t;

    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] fmt_data;
    logic        fmt_err;

    assign addr_lo = mem_alu_result[1:0];

`ifndef WB_LWLR_EN
    logic unused_rt;
    assign unused_rt = ^mem_rt_data;
`endif

    // Select the addressed byte/halfword and build the write-back value.
    always_comb begin
        ld_byte  = mem_rdata[7:0];
        ld_half  = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        fmt_data = mem_alu_result;
        fmt_err  = 1'b0;
        case (addr_lo)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        case (load_op_t'(mem_load_op))
            LD_NONE: fmt_data = mem_alu_result;
            LD_LB:   fmt_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  fmt_data = {24'd0, ld_byte};
            LD_LH: begin
                fmt_data = {{16{ld_half[15]}}, ld_half};
                fmt_err  = addr_lo[0];
            end
            LD_LHU: begin
                fmt_data = {16'd0, ld_half};
                fmt_err  = addr_lo[0];
            end
            LD_LW: begin
                fmt_data = mem_rdata;
                fmt_err  = (addr_lo != 2'd0);
            end
`ifdef WB_LWLR_EN
            LD_LWL: begin
                case (addr_lo)
                    2'd0: fmt_data = {mem_rdata[7:0],  mem_rt_data[23:0]};
                    2'd1: fmt_data = {mem_rdata[15:0], mem_rt_data[15:0]};
                    2'd2: fmt_data = {mem_rdata[23:0], mem_rt_data[7:0]};
                    default: fmt_data = mem_rdata;
                endcase
            end
            LD_LWR: begin
                case (addr_lo)
                    2'd0: fmt_data = mem_rdata;
                    2'd1: fmt_data = {mem_rt_data[31:24], mem_rdata[31:8]};
                    2'd2: fmt_data = {mem_rt_data[31:16], mem_rdata[31:16]};
                    default: fmt_data = {mem_rt_data[31:8], mem_rdata[31:24]};
                endcase
            end
`else
            LD_LWL, LD_LWR: begin
                fmt_data = mem_rdata;
                fmt_err  = 1'b1;
            end
`endif
            default: fmt_data = mem_alu_result;
        endcase
    end

    // WB slot register: reset > flush > stall > capture; instret survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr    <= '0;
            wdata    <= '0;
            we       <= 1'b0;
            wb_valid <= 1'b0;
            wb_pc    <= RESET_PC;
            load_err <= 1'b0;
            instret  <= '0;
        end else if (flush) begin
            waddr    <= '0;
            wdata    <= '0;
            we       <= 1'b0;
            wb_valid <= 1'b0;
            wb_pc    <= RESET_PC;
            load_err <= 1'b0;
        end else if (!stall) begin
            waddr    <= mem_waddr;
            wdata    <= fmt_data;
            we       <= mem_valid & mem_we & (mem_waddr != '0) & ~fmt_err;
            wb_valid <= mem_valid;
            wb_pc    <= mem_pc;
            load_err <= mem_valid & fmt_err;
            if (mem_valid)
                instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases plus randomized traffic checked
// against a behavioural model of the WB slot and load formatting.
module tb_mem_wb_stage;

    localparam logic [31:0] RPC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_valid, mem_we;
    logic [31:0] mem_pc, mem_alu_result, mem_rdata, mem_rt_data;
    logic [4:0]  mem_waddr;
    logic [2:0]  mem_load_op;
    logic [4:0]  waddr;
    logic [31:0] wdata, wb_pc, instret;
    logic        we, wb_valid, load_err;

    int checks = 0;
    int failures = 0;

    // model state
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc, m_instret;
    logic        m_we, m_valid, m_err, m_dok;

    always #5 clk = ~clk;

    mem_wb_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_alu_result(mem_alu_result),
        .mem_load_op(mem_load_op), .mem_rdata(mem_rdata),
        .mem_rt_data(mem_rt_data), .waddr(waddr), .wdata(wdata), .we(we),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .load_err(load_err),
        .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [2:0] op, input int unsigned a);
`ifdef WB_LWLR_EN
        return ((op == 3 || op == 4) && (a % 2 == 1)) || (op == 5 && a != 0);
`else
        return ((op == 3 || op == 4) && (a % 2 == 1)) || (op == 5 && a != 0) || op >= 6;
`endif
    endfunction

    function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] alu,
                                             input logic [31:0] rd, input logic [31:0] rt);
        int unsigned a;
        logic [7:0]  b;
        logic [15:0] h;
        logic [63:0] t, keep;
        a = alu % 4;
        b = 8'(rd >> (8 * a));
        h = 16'(rd >> (16 * (a / 2)));
        case (op)
            3'd1: return 32'($signed(b));
            3'd2: return 32'(b);
            3'd3: return 32'($signed(h));
            3'd4: return 32'(h);
            3'd5: return rd;
            3'd6: begin
                t    = {32'd0, rd} << (8 * (3 - a));
                keep = (64'd1 << (8 * (3 - a))) - 64'd1;
                return t[31:0] | (rt & keep[31:0]);
            end
            3'd7: return (rd >> (8 * a)) | (rt & ~(32'hFFFFFFFF >> (8 * a)));
            default: return alu;
        endcase
    endfunction

    task automatic model_update();
        logic e;
        e = ref_err(mem_load_op, mem_alu_result % 4);
        if (rst || flush) begin
            m_waddr = '0; m_wdata = '0; m_we = 1'b0; m_valid = 1'b0;
            m_pc = RPC; m_err = 1'b0; m_dok = 1'b1;
            if (rst) m_instret = '0;
        end else if (!stall) begin
            m_waddr = mem_waddr;
            m_wdata = ref_data(mem_load_op, mem_alu_result, mem_rdata, mem_rt_data);
            m_dok   = !e;
            m_we    = mem_valid && mem_we && mem_waddr != 0 && !e;
            m_valid = mem_valid;
            m_pc    = mem_pc;
            m_err   = mem_valid && e;
            if (mem_valid) m_instret = m_instret + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("we", 32'(we), 32'(m_we));
        chk("waddr", 32'(waddr), 32'(m_waddr));
        chk("wb_valid", 32'(wb_valid), 32'(m_valid));
        chk("wb_pc", wb_pc, m_pc);
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("instret", instret, m_instret);
        if (m_dok) chk("wdata", wdata, m_wdata);
    endtask

    task automatic set(input logic v, input logic w, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [2:0] op, input logic [31:0] rd, input logic [31:0] rt,
                       input logic [31:0] pc);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = v; mem_we = w; mem_waddr = wa; mem_alu_result = alu;
        mem_load_op = op; mem_rdata = rd; mem_rt_data = rt; mem_pc = pc;
    endtask

    initial begin
        m_instret = '0;
        set(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("reset_wb_pc", wb_pc, RPC);
        chk("reset_instret", instret, 32'd0);

        // LB / LBU at byte 3
        set(1, 1, 5, 32'h1003, 1, 32'h80FF1234, 0, 32'h100);
        step();
        chk("lb_wdata", wdata, 32'hFFFFFF80);
        chk("lb_we", 32'(we), 32'd1);
        set(1, 1, 5, 32'h1003, 2, 32'h80FF1234, 0, 32'h104);
        step();
        chk("lbu_wdata", wdata, 32'h00000080);

        // LH at halfword 1, then misaligned LW
        set(1, 1, 6, 32'h2002, 3, 32'h9ABC1234, 0, 32'h108);
        step();
        chk("lh_wdata", wdata, 32'hFFFF9ABC);
        set(1, 1, 6, 32'h2001, 5, 32'h9ABC1234, 0, 32'h10C);
        step();
        chk("lw_mis_we", 32'(we), 32'd0);
        chk("lw_mis_err", 32'(load_err), 32'd1);
        chk("lw_mis_valid", 32'(wb_valid), 32'd1);

        // LWL a=1, LWR a=2
        set(1, 1, 9, 32'h3001, 6, 32'h11223344, 32'hAABBCCDD, 32'h110);
        step();
`ifdef WB_LWLR_EN
        chk("lwl_wdata", wdata, 32'h3344CCDD);
`else
        chk("lwl_err", 32'(load_err), 32'd1);
`endif
        set(1, 1, 9, 32'h3002, 7, 32'h11223344, 32'hAABBCCDD, 32'h114);
        step();
`ifdef WB_LWLR_EN
        chk("lwr_wdata", wdata, 32'hAABB1122);
`else
        chk("lwr_err", 32'(load_err), 32'd1);
`endif

        // ALU write to $0
        set(1, 1, 0, 32'h5, 0, 32'hDEADBEEF, 0, 32'h118);
        step();
        chk("r0_we", 32'(we), 32'd0);
        chk("r0_instret", instret, 32'd7);

        // capture then stall 3 cycles with changing inputs
        set(1, 1, 7, 32'h1234, 0, 0, 0, 32'h11C);
        step();
        for (int i = 0; i < 3; i++) begin
            set(1, 1, 5'(i + 1), $urandom, 3'($urandom), $urandom, $urandom, $urandom);
            stall = 1'b1;
            step();
            chk("stall_wdata", wdata, 32'h1234);
            chk("stall_instret", instret, 32'd8);
        end
        flush = 1'b1;
        step();
        chk("flush_pc", wb_pc, RPC);
        chk("flush_valid", 32'(wb_valid), 32'd0);

        // instret wrap via forced preload
        set(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        force dut.instret = 32'hFFFFFFFF;
        #1;
        release dut.instret;
        m_instret = 32'hFFFFFFFF;
        chk("preload_instret", instret, 32'hFFFFFFFF);
        set(1, 1, 3, 32'h77, 0, 0, 0, 32'h200);
        step();
        chk("wrap_instret", instret, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                $urandom, 3'($urandom), $urandom, $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            step();
        end

        // reset mid-stream
        set(1, 1, 4, 32'h99, 0, 0, 0, 32'h300);
        step();
        rst = 1'b1;
        step();
        chk("rst_instret", instret, 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wdata", wdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
